// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   OP_MUL / OP_DIV  operation select values for the op input
//   state_e          FSM state encoding (IDLE / RUN / FIX)
//   twos_neg()       two's-complement negate on a MAX_W-bit carrier; callers
//                    truncate to their own width (valid for any width <= MAX_W)
package mdu_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Widest value ever negated is the 2N-bit product, so N may go up to 64.
  localparam int MAX_W = 128;
  typedef logic [MAX_W-1:0] wide_t;

  function automatic wide_t twos_neg(input wide_t x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request/result bundle between the EX stage and mdu_seq.
//   master: start, op, sgn, a, b, hi_we, lo_we, wdata -> ; <- busy, done, dbz, hi, lo
//   slave : the mirror image, used by mdu_seq.
interface mdu_seq_if #(parameter int N = 32);
  logic         start;
  logic         op;
  logic         sgn;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [N-1:0] wdata;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  modport master (
    output start, op, sgn, a, b, hi_we, lo_we, wdata,
    input  busy, done, dbz, hi, lo
  );

  modport slave (
    input  start, op, sgn, a, b, hi_we, lo_we, wdata,
    output busy, done, dbz, hi, lo
  );
endinterface

// File: rtl/mdu_negmag.sv
// mdu_negmag: combinational conditional two's-complement negate.
//   neg  in  1  1 = output -val, 0 = output val
//   val  in  W  operand
//   res  out W  result
// Used both to take operand magnitudes and to re-apply result signs.
module mdu_negmag
  import mdu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] val,
  output logic [W-1:0] res
);

  always_comb begin
    res = neg ? W'(twos_neg(wide_t'(val))) : val;
  end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide unit with HI/LO result registers.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous reset, active low
//   bus    slave modport of mdu_seq_if:
//            start/op/sgn/a/b   launch MULT(U)/DIV(U) (sampled in IDLE only)
//            hi_we/lo_we/wdata  MTHI/MTLO (IDLE only)
//            busy/done/dbz      handshake; done and dbz are one-cycle pulses
//            hi/lo              mult: product high/low; div: remainder/quotient
// One radix-2 step per cycle on unsigned magnitudes (shift-add / restoring),
// sign correction in FIX. Result is visible N+1 cycles after the start edge.
// Build option: define MDU_DIV_EN to include the divider. Without it, a divide
// request raises busy for one cycle, then pulses done+dbz with HI/LO untouched.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int N = 32
) (
  input logic       clk,
  input logic       rst_n,
  mdu_seq_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [N-1:0]    opd_q, opd_d;     // multiplicand or divisor magnitude
  logic            sgn_p_q, sgn_p_d; // product / quotient sign
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;
  logic [N-1:0]    hi_q, hi_d;
  logic [N-1:0]    lo_q, lo_d;
`ifdef MDU_DIV_EN
  logic            op_q, op_d;
  logic            sgn_r_q, sgn_r_d; // remainder sign
  logic            dz_q, dz_d;       // divisor was zero
`else
  logic            pend_q, pend_d;   // divide request awaiting its dbz reply
`endif

  logic [N-1:0]    mag_a, mag_b;
  logic [2*N-1:0]  fix_p;
  logic [N:0]      mul_sum;
  logic [2*N-1:0]  mul_nxt;

  mdu_negmag #(.W(N)) u_abs_a (
    .neg (bus.sgn & bus.a[N-1]),
    .val (bus.a),
    .res (mag_a)
  );

  mdu_negmag #(.W(N)) u_abs_b (
    .neg (bus.sgn & bus.b[N-1]),
    .val (bus.b),
    .res (mag_b)
  );

  mdu_negmag #(.W(2*N)) u_fix_p (
    .neg (sgn_p_q),
    .val (acc_q),
    .res (fix_p)
  );

  // Shift-add: acc = {partial product, remaining multiplier bits}.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_nxt = {mul_sum, acc_q[N-1:1]};
  end

`ifdef MDU_DIV_EN
  logic [N-1:0]    fix_r, fix_q;
  logic [N:0]      div_sh;
  logic            div_ok;
  logic [N-1:0]    div_diff;
  logic [2*N-1:0]  div_nxt;

  mdu_negmag #(.W(N)) u_fix_r (
    .neg (sgn_r_q),
    .val (acc_q[2*N-1:N]),
    .res (fix_r)
  );

  mdu_negmag #(.W(N)) u_fix_q (
    .neg (sgn_p_q),
    .val (acc_q[N-1:0]),
    .res (fix_q)
  );

  // Restoring: acc = {partial remainder, dividend bits -> quotient bits}.
  // The true difference is below the divisor, so N bits of it suffice.
  always_comb begin
    div_sh   = {acc_q[2*N-1:N], acc_q[N-1]};
    div_ok   = (div_sh >= {1'b0, opd_q});
    div_diff = div_sh[N-1:0] - opd_q;
    div_nxt  = div_ok ? {div_diff, acc_q[N-2:0], 1'b1}
                      : {div_sh[N-1:0], acc_q[N-2:0], 1'b0};
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    sgn_p_d = sgn_p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_DIV_EN
    op_d    = op_q;
    sgn_r_d = sgn_r_q;
    dz_d    = dz_q;
`else
    pend_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifndef MDU_DIV_EN
        if (pend_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          dbz_d  = 1'b1;
        end else begin
`endif
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
          if (bus.start) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            sgn_p_d = bus.sgn & (bus.a[N-1] ^ bus.b[N-1]);
`ifdef MDU_DIV_EN
            state_d = RUN;
            op_d    = bus.op;
            sgn_r_d = bus.sgn & bus.a[N-1];
            dz_d    = (bus.b == '0);
            if (bus.op == OP_DIV) begin
              opd_d = mag_b;
              acc_d = {{N{1'b0}}, mag_a};
            end else begin
              opd_d = mag_a;
              acc_d = {{N{1'b0}}, mag_b};
            end
`else
            if (bus.op == OP_DIV) begin
              pend_d = 1'b1;
            end else begin
              state_d = RUN;
              opd_d   = mag_a;
              acc_d   = {{N{1'b0}}, mag_b};
            end
`endif
          end
`ifndef MDU_DIV_EN
        end
`endif
      end
      RUN: begin
`ifdef MDU_DIV_EN
        acc_d = (op_q == OP_DIV) ? div_nxt : mul_nxt;
`else
        acc_d = mul_nxt;
`endif
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef MDU_DIV_EN
        if (op_q == OP_DIV) begin
          // Zero divisor leaves the dividend as remainder, so fix_r is the original a.
          hi_d  = fix_r;
          lo_d  = dz_q ? '1 : fix_q;
          dbz_d = dz_q;
        end else begin
          {hi_d, lo_d} = fix_p;
        end
`else
        {hi_d, lo_d} = fix_p;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      sgn_p_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_DIV_EN
      op_q    <= 1'b0;
      sgn_r_q <= 1'b0;
      dz_q    <= 1'b0;
`else
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      sgn_p_q <= sgn_p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_DIV_EN
      op_q    <= op_d;
      sgn_r_q <= sgn_r_d;
      dz_q    <= dz_d;
`else
      pend_q  <= pend_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed, table-driven bench for mdu_seq (N=32) plus hand-written
// handshake and mid-operation reset sequences. Follows MDU_DIV_EN if defined.
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int N = 32;

  logic clk;
  logic rst_n;

  mdu_seq_if #(.N(N)) bus ();

  mdu_seq #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic         sgn;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic op, input logic sgn, input logic [N-1:0] a,
                              input logic [N-1:0] b, input logic [N-1:0] hi,
                              input logic [N-1:0] lo, input logic dbz, input int lat);
    vec_t v;
    v.op = op; v.sgn = sgn; v.a = a; v.b = b;
    v.hi = hi; v.lo = lo; v.dbz = dbz; v.lat = lat;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, scramble the operands right after the start edge, then wait
  // (bounded) for done. lat counts edges after the start edge; bcyc counts
  // samples with busy high.
  task automatic run_op(input logic op, input logic sgn, input logic [N-1:0] a,
                        input logic [N-1:0] b, output int lat, output int bcyc,
                        output logic [N-1:0] hi, output logic [N-1:0] lo,
                        output logic dbz);
    bus.op = op; bus.sgn = sgn; bus.a = a; bus.b = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    bus.op = 1'($urandom_range(0, 1)); bus.sgn = 1'($urandom_range(0, 1));
    lat = 0; bcyc = 0;
    if (bus.busy) bcyc++;
    while (!bus.done && lat < N + 8) begin
      tick();
      lat++;
      if (bus.busy) bcyc++;
    end
    hi = bus.hi; lo = bus.lo; dbz = bus.dbz;
  endtask

  initial begin
    int lat, bcyc, cnt;
    logic [N-1:0] rhi, rlo, hi_before;
    logic rdbz, rst_op;
    n_cmp = 0; n_bad = 0;

    // Multiply vectors (latency N+1)
    vecs.push_back(mk(OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, N+1));
    vecs.push_back(mk(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, N+1));
    vecs.push_back(mk(OP_MUL, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, N+1));
    vecs.push_back(mk(OP_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, N+1));
    vecs.push_back(mk(OP_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, N+1));
    vecs.push_back(mk(OP_MUL, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 1'b0, N+1));
    vecs.push_back(mk(OP_MUL, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, N+1));
    vecs.push_back(mk(OP_MUL, 1'b1, 32'h0000_0005, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, N+1));
    vecs.push_back(mk(OP_MUL, 1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b0, N+1));
`ifdef MDU_DIV_EN
    vecs.push_back(mk(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, N+1));
    vecs.push_back(mk(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, N+1));
    vecs.push_back(mk(OP_DIV, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, N+1));
    vecs.push_back(mk(OP_DIV, 1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, N+1));
    vecs.push_back(mk(OP_DIV, 1'b0, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, N+1));
    vecs.push_back(mk(OP_DIV, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, N+1));
    vecs.push_back(mk(OP_DIV, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, N+1));
    vecs.push_back(mk(OP_DIV, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, N+1));
    vecs.push_back(mk(OP_DIV, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 1'b0, N+1));
    rst_op = OP_DIV;
`else
    // Divider absent: one-cycle busy, done+dbz, HI/LO keep the previous product.
    vecs.push_back(mk(OP_DIV, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1));
    vecs.push_back(mk(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b1, 1));
    rst_op = OP_MUL;
`endif

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 1'b0; bus.sgn = 1'b0; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dbz",  64'(bus.dbz),  64'd0);
    chk("rst_hi",   64'(bus.hi),   64'd0);
    chk("rst_lo",   64'(bus.lo),   64'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, lat, bcyc, rhi, rlo, rdbz);
      chk($sformatf("v%0d_latency", i), 64'(lat),  64'(vecs[i].lat));
      chk($sformatf("v%0d_busy_cyc", i), 64'(bcyc), 64'(vecs[i].lat));
      chk($sformatf("v%0d_hi", i),  64'(rhi),  64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i),  64'(rlo),  64'(vecs[i].lo));
      chk($sformatf("v%0d_dbz", i), 64'(rdbz), 64'(vecs[i].dbz));
      tick();
      chk($sformatf("v%0d_done_pulse", i), 64'({bus.done, bus.dbz}), 64'd0);
    end

    // Mid-operation reset: outputs clear at once and no done follows.
    bus.op = rst_op; bus.sgn = 1'b1; bus.a = 32'h0000_1000; bus.b = 32'h0000_0003;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (15) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_hi",   64'(bus.hi),   64'd0);
    chk("mid_rst_lo",   64'(bus.lo),   64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    repeat (N + 5) begin
      tick();
      if (bus.done || bus.busy) cnt++;
    end
    chk("mid_rst_no_done", 64'(cnt), 64'd0);

    run_op(OP_MUL, 1'b1, 32'h0000_1234, 32'hFFFF_FFFE, lat, bcyc, rhi, rlo, rdbz);
    chk("post_rst_lat", 64'(lat), 64'(N + 1));
    chk("post_rst_hi",  64'(rhi), 64'hFFFF_FFFF);
    chk("post_rst_lo",  64'(rlo), 64'hFFFF_DB98);
    tick();

    // Second start and MTHI during a multiply are ignored.
    hi_before = bus.hi;
    bus.op = OP_MUL; bus.sgn = 1'b0; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    repeat (10) begin tick(); lat++; end
    bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd9; bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
    tick();
    lat++;
    bus.start = 1'b0; bus.hi_we = 1'b0;
    chk("hs_busy_mid", 64'(bus.busy), 64'd1);
    chk("hs_hi_hold",  64'(bus.hi),   64'(hi_before));
    while (!bus.done && lat < N + 8) begin tick(); lat++; end
    chk("hs_lat", 64'(lat),    64'(N + 1));
    chk("hs_hi",  64'(bus.hi), 64'd0);
    chk("hs_lo",  64'(bus.lo), 64'd15);
    tick();

    // MTHI in IDLE lands next cycle; MTHI+MTLO together write both.
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
    tick();
    bus.hi_we = 1'b0;
    chk("mthi_hi", 64'(bus.hi), 64'h0000_1234);
    chk("mthi_lo", 64'(bus.lo), 64'd15);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_5A5A;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    chk("mthilo", 64'({bus.hi, bus.lo}), 64'hA5A5_5A5A_A5A5_5A5A);

    // MTHI on the start edge applies, then the result overwrites it.
    bus.op = OP_MUL; bus.sgn = 1'b0; bus.a = 32'd2; bus.b = 32'd3;
    bus.start = 1'b1; bus.hi_we = 1'b1; bus.wdata = 32'h0000_0777;
    tick();
    bus.start = 1'b0; bus.hi_we = 1'b0;
    chk("st_we_hi", 64'(bus.hi), 64'h0000_0777);
    lat = 0;
    while (!bus.done && lat < N + 8) begin tick(); lat++; end
    chk("st_we_lat", 64'(lat), 64'(N + 1));
    chk("st_we_res", 64'({bus.hi, bus.lo}), 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
